hazard_detect: RTL and testbench
================================

// Module: hazard_detect
// PURPOSE
//  ID-stage RAW hazard detector for the 5-stage non-forwarding pipeline.
//  Tracks in-flight destination registers in EX and MEM with a 2-slot scoreboard.
//  Compares them against the ID instruction's sources and issues a one-shot
//  stall request (stall_count) to the stall controller. Also drives the bubble
//  (NOP insert) into ID/EX.
//  Regfile writes in WB bypass to same-cycle reads, so a WB match never stalls.
// PARAMETERS
//  RAW  3  register address width (8 GPRs)
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous active-high reset
//  id_valid     in   1    ID/EX-bound instruction is real (not a NOP)
//  id_rs_en     in   1    instruction reads rs
//  id_rs        in   RAW  rs address
//  id_rt_en     in   1    instruction reads rt
//  id_rt        in   RAW  rt address
//  id_wen       in   1    instruction writes a register
//  id_rd        in   RAW  destination address
//  flush        in   1    taken branch/jump; kills the ID instruction this cycle
//  stall_count  out  2    one-shot request: 0 none, 1 or 2 stall cycles, 3 never driven
//  bubble       out  1    replace ID/EX input with NOP this cycle
//  err          out  1    internal illegal state (hold_cnt==3)
// BEHAVIOUR
//  State
//   - slot_ex = {v, reg}, slot_mem = {v, reg}.
//   - hold_cnt[1:0] = remaining stall cycles already requested.
//  Reset
//   - All state cleared.
//   - Outputs after reset: stall_count=0, bubble=0, err=0.
//  Hazard detection (combinational, only when hold_cnt==0 && id_valid && !flush)
//   - hit_ex  = slot_ex.v  && ((id_rs_en && id_rs==slot_ex.reg) || (id_rt_en && id_rt==slot_ex.reg))
//   - hit_mem = same test against slot_mem
//   - stall_count = hit_ex ? 2 : hit_mem ? 1 : 0
//   - When hold_cnt != 0, stall_count=0 (request is never re-issued during a stall).
//  Bubble
//   - bubble = (stall_count!=0) || (hold_cnt!=0) || flush
//   - No extra register stage: bubble is asserted in the same cycles the stall
//     controller holds PC/IF-ID.
//  Sequential update (every cycle)
//   - slot_mem <= slot_ex
//   - slot_ex  <= bubble ? {0,x} : {id_valid && id_wen, id_rd}
//   - hold_cnt <= flush ? 0 : (stall_count!=0) ? stall_count-1 : (hold_cnt!=0 ? hold_cnt-1 : 0)
//  Timing
//   - Stall of N cycles: N consecutive bubble cycles starting with the request cycle.
//   - The ID instruction is re-evaluated in the cycle after the last bubble;
//     by then its producer has reached WB, so it issues with no further stall.
//  Boundaries and corner cases
//   - Hazard on both rs and rt: single request; EX match takes priority.
//   - flush during hold: hold_cnt cleared, that cycle is a bubble.
//   - flush together with a hazard: the hazard is ignored.
//   - id_wen with id_valid=0: not tracked.
//   - Every register, including R0, is a real GPR and is tracked.
//   - Reset mid-stall: hold_cnt and both slots cleared; next cycle is a fresh evaluation.
//  Error output
//   - err = (hold_cnt==3), combinational; unreachable in correct operation.
// TESTING
//  1. Reset 2 cycles -> stall_count=0, bubble=0, err=0; both slots invalid.
//  2. ADD R1 <- ..., then SUB reading R1 the next cycle ->
//     stall_count=2 for 1 cycle, bubble=1 for 2 cycles, SUB issues on 3rd cycle.
//  3. Writer of R3, unrelated instruction, then reader of R3 ->
//     stall_count=1, bubble for 1 cycle.
//  4. Reader of R5 three instructions after writer of R5 -> no stall (WB bypass).
//  5. EX-hazard request, flush in the following cycle ->
//     hold_cnt=0, bubble=1 that cycle, next ID instruction evaluated fresh.
//  6. Back-to-back hazards A->B->C (each reads the previous dest) ->
//     two separate stall_count=2 pulses, no re-issue during hold, err stays 0.

Source files
------------

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// ID-stage read-after-write hazard detector for a 5-stage pipeline without
// forwarding. A two-entry scoreboard follows the destination registers of the
// instructions currently in EX and MEM. When the instruction in ID reads one of
// them, a one-shot stall request is raised (2 cycles for an EX producer,
// 1 cycle for a MEM producer). A bubble (NOP into ID/EX) is driven for every
// cycle of the stall and for flushed cycles. A producer in WB never stalls
// because the register file bypasses same-cycle writes to reads.
// ---------------------------------------------------------------------------
module hazard_detect #(
  parameter int RAW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic           id_rs_en,
  input  logic [RAW-1:0] id_rs,
  input  logic           id_rt_en,
  input  logic [RAW-1:0] id_rt,
  input  logic           id_wen,
  input  logic [RAW-1:0] id_rd,
  input  logic           flush,
  output logic [1:0]     stall_count,
  output logic           bubble,
  output logic           err
);

  // Scoreboard slot for the instruction in EX
  logic           slot_ex_v_r;
  logic [RAW-1:0] slot_ex_reg_r;
  // Scoreboard slot for the instruction in MEM
  logic           slot_mem_v_r;
  logic [RAW-1:0] slot_mem_reg_r;
  // Stall cycles still owed after the request cycle
  logic [1:0]     hold_cnt_r;

  logic           eval_en_s;
  logic           hit_ex_s;
  logic           hit_mem_s;
  logic [1:0]     stall_count_s;
  logic           bubble_s;
  logic           slot_ex_v_nxt_s;
  logic [RAW-1:0] slot_ex_reg_nxt_s;
  logic [1:0]     hold_cnt_nxt_s;

  // True when a valid scoreboard slot matches any enabled source operand.
  function automatic logic src_hit(
    input logic           slot_v,
    input logic [RAW-1:0] slot_reg,
    input logic           rs_en,
    input logic [RAW-1:0] rs,
    input logic           rt_en,
    input logic [RAW-1:0] rt
  );
    logic rs_match;
    logic rt_match;
    rs_match = rs_en && (rs == slot_reg);
    rt_match = rt_en && (rt == slot_reg);
    return slot_v && (rs_match || rt_match);
  endfunction

  // Hazard evaluation: only a fresh, real, un-flushed ID instruction is checked.
  always_comb begin
    eval_en_s     = 1'b0;
    hit_ex_s      = 1'b0;
    hit_mem_s     = 1'b0;
    stall_count_s = 2'd0;
    eval_en_s = (hold_cnt_r == 2'd0) && id_valid && !flush;
    hit_ex_s  = src_hit(slot_ex_v_r,  slot_ex_reg_r,  id_rs_en, id_rs, id_rt_en, id_rt);
    hit_mem_s = src_hit(slot_mem_v_r, slot_mem_reg_r, id_rs_en, id_rs, id_rt_en, id_rt);
    if (!eval_en_s) begin
      stall_count_s = 2'd0;
    end else if (hit_ex_s) begin
      // EX producer needs two cycles to reach WB; it wins over a MEM match.
      stall_count_s = 2'd2;
    end else if (hit_mem_s) begin
      stall_count_s = 2'd1;
    end else begin
      stall_count_s = 2'd0;
    end
  end

  // Bubble whenever a stall is requested or running, or the ID slot is flushed.
  always_comb begin
    bubble_s = 1'b0;
    if ((stall_count_s != 2'd0) || (hold_cnt_r != 2'd0) || flush) begin
      bubble_s = 1'b1;
    end else begin
      bubble_s = 1'b0;
    end
  end

  // Next-state for the EX slot: a bubble carries no destination.
  always_comb begin
    slot_ex_v_nxt_s   = 1'b0;
    slot_ex_reg_nxt_s = {RAW{1'b0}};
    if (bubble_s) begin
      slot_ex_v_nxt_s   = 1'b0;
      slot_ex_reg_nxt_s = {RAW{1'b0}};
    end else begin
      slot_ex_v_nxt_s   = id_valid && id_wen;
      slot_ex_reg_nxt_s = id_rd;
    end
  end

  // Next-state for the hold counter: flush cancels, a new request loads,
  // otherwise an active hold counts down to zero.
  always_comb begin
    hold_cnt_nxt_s = 2'd0;
    if (flush) begin
      hold_cnt_nxt_s = 2'd0;
    end else if (stall_count_s != 2'd0) begin
      hold_cnt_nxt_s = stall_count_s - 2'd1;
    end else if (hold_cnt_r != 2'd0) begin
      hold_cnt_nxt_s = hold_cnt_r - 2'd1;
    end else begin
      hold_cnt_nxt_s = 2'd0;
    end
  end

  // Scoreboard and hold counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_ex_v_r    <= 1'b0;
      slot_ex_reg_r  <= {RAW{1'b0}};
      slot_mem_v_r   <= 1'b0;
      slot_mem_reg_r <= {RAW{1'b0}};
      hold_cnt_r     <= 2'd0;
    end else begin
      slot_mem_v_r   <= slot_ex_v_r;
      slot_mem_reg_r <= slot_ex_reg_r;
      slot_ex_v_r    <= slot_ex_v_nxt_s;
      slot_ex_reg_r  <= slot_ex_reg_nxt_s;
      hold_cnt_r     <= hold_cnt_nxt_s;
    end
  end

  // Outputs are combinational so the stall controller sees them in the
  // same cycle as the hazard.
  always_comb begin
    stall_count = stall_count_s;
    bubble      = bubble_s;
    err         = (hold_cnt_r == 2'd3);
  end

endmodule

// File: tb/tb_hazard_detect.sv
// ---------------------------------------------------------------------------
// tb_hazard_detect
// Directed table of pipeline scenarios, hand-written reset sequences, and a
// randomized run compared against a distance-based reference model.
// ---------------------------------------------------------------------------
module tb_hazard_detect;

  localparam int RAW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           id_valid;
  logic           id_rs_en;
  logic [RAW-1:0] id_rs;
  logic           id_rt_en;
  logic [RAW-1:0] id_rt;
  logic           id_wen;
  logic [RAW-1:0] id_rd;
  logic           flush;
  logic [1:0]     stall_count;
  logic           bubble;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_detect #(.RAW(RAW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs_en    (id_rs_en),
    .id_rs       (id_rs),
    .id_rt_en    (id_rt_en),
    .id_rt       (id_rt),
    .id_wen      (id_wen),
    .id_rd       (id_rd),
    .flush       (flush),
    .stall_count (stall_count),
    .bubble      (bubble),
    .err         (err)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  typedef struct {
    logic           valid;
    logic           rs_en;
    logic [RAW-1:0] rs;
    logic           rt_en;
    logic [RAW-1:0] rt;
    logic           wen;
    logic [RAW-1:0] rd;
    logic           fl;
    logic [1:0]     exp_stall;
    logic           exp_bubble;
  } vec_t;

  localparam int NVEC = 30;
  vec_t tbl [NVEC];

  // Reference model: the last two issued instructions, newest first; bit 3 = writes a register
  logic [3:0] hist_q [$];
  int         rem;

  function automatic vec_t mk(input logic v, input logic rse, input int rsa,
                              input logic rte, input int rta, input logic we,
                              input int rda, input logic f, input int es, input logic eb);
    vec_t t;
    t.valid = v;   t.rs_en = rse; t.rs = 3'(rsa);
    t.rt_en = rte; t.rt = 3'(rta); t.wen = we; t.rd = 3'(rda);
    t.fl = f; t.exp_stall = 2'(es); t.exp_bubble = eb;
    return t;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    id_valid = v.valid; id_rs_en = v.rs_en; id_rs = v.rs;
    id_rt_en = v.rt_en; id_rt = v.rt; id_wen = v.wen; id_rd = v.rd;
    flush = v.fl;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] es, input logic eb);
    check({tag, ".stall_count"}, {2'b00, stall_count}, {2'b00, es});
    check({tag, ".bubble"}, {3'b000, bubble}, {3'b000, eb});
    check({tag, ".err"}, {3'b000, err}, 4'd0);
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_rs_en = 1'b0; id_rs = 3'd0; id_rt_en = 1'b0;
    id_rt = 3'd0; id_wen = 1'b0; id_rd = 3'd0; flush = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    repeat (n) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic model_reset();
    hist_q.delete();
    hist_q.push_back(4'd0);
    hist_q.push_back(4'd0);
    rem = 0;
  endtask

  // Stalls needed = 3 - distance to the nearest in-flight producer of a source
  // (distance 1 = EX, 2 = MEM, 3+ = already written back).
  task automatic model_step(input vec_t v, output logic [1:0] es, output logic eb);
    int need;
    logic [3:0] issue;
    need  = 0;
    issue = 4'd0;
    if (v.fl) begin
      es = 2'd0; eb = 1'b1; rem = 0;
    end else if (rem > 0) begin
      es = 2'd0; eb = 1'b1; rem = rem - 1;
    end else begin
      if (v.valid) begin
        for (int d = 1; d <= 2; d++) begin
          if (hist_q[d-1][3] &&
              ((v.rs_en && v.rs == hist_q[d-1][2:0]) ||
               (v.rt_en && v.rt == hist_q[d-1][2:0]))) begin
            if (3 - d > need) need = 3 - d;
          end
        end
      end
      es = 2'(need);
      eb = (need != 0);
      if (need > 0) rem = need - 1;
      else issue = {v.valid && v.wen, v.rd};
    end
    hist_q.push_front(issue);
    void'(hist_q.pop_back());
  endtask

  initial begin
    vec_t v;
    logic [1:0] es;
    logic eb;
    logic r;

    rst = 1'b0;
    set_idle();

    // Reset for two cycles; outputs quiescent with idle inputs
    do_reset(2);
    check_outs("reset", 2'd0, 1'b0);

    //              v  rse rs rte rt we rd fl  es eb
    tbl[0]  = mk(1, 1, 2, 1, 3, 1, 1, 0, 0, 0); // ADD R1
    tbl[1]  = mk(1, 1, 1, 1, 4, 1, 5, 0, 2, 1); // SUB reads R1 -> EX hazard
    tbl[2]  = mk(1, 1, 1, 1, 4, 1, 5, 0, 0, 1); // held
    tbl[3]  = mk(1, 1, 1, 1, 4, 1, 5, 0, 0, 0); // SUB issues
    tbl[4]  = mk(1, 1, 6, 1, 7, 1, 3, 0, 0, 0); // writer R3
    tbl[5]  = mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0); // unrelated, writes R6
    tbl[6]  = mk(1, 1, 3, 0, 6, 0, 0, 0, 1, 1); // reads R3 (MEM); rt disabled
    tbl[7]  = mk(1, 1, 3, 0, 6, 0, 0, 0, 0, 0); // issues
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); // writer R5
    tbl[9]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    tbl[11] = mk(1, 1, 5, 1, 5, 1, 7, 0, 0, 0); // R5 now in WB: no stall
    tbl[12] = mk(1, 0, 0, 1, 7, 1, 4, 0, 2, 1); // EX hazard via rt
    tbl[13] = mk(1, 0, 0, 1, 7, 1, 4, 1, 0, 1); // flush during hold
    tbl[14] = mk(1, 1, 2, 0, 0, 1, 0, 0, 0, 0); // fresh eval; writes R0
    tbl[15] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 1); // hazard on R0 + flush: ignored
    tbl[16] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1); // R0 tracked, now in MEM
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 3, 0, 0, 0); // invalid writer: not tracked
    tbl[18] = mk(1, 1, 3, 0, 0, 1, 3, 0, 0, 0); // A writes R3
    tbl[19] = mk(1, 1, 3, 0, 0, 1, 4, 0, 2, 1); // B reads R3
    tbl[20] = mk(1, 1, 3, 0, 0, 1, 4, 0, 0, 1); // no re-issue during hold
    tbl[21] = mk(1, 1, 3, 0, 0, 1, 4, 0, 0, 0); // B issues
    tbl[22] = mk(1, 1, 4, 1, 4, 0, 0, 0, 2, 1); // C reads R4 on rs and rt
    tbl[23] = mk(1, 1, 4, 1, 4, 0, 0, 0, 0, 1);
    tbl[24] = mk(1, 1, 4, 1, 4, 0, 0, 0, 0, 0);
    tbl[25] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); // writer R1
    tbl[26] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); // writer R2
    tbl[27] = mk(1, 1, 1, 1, 2, 0, 0, 0, 2, 1); // rs hits MEM, rt hits EX: EX wins
    tbl[28] = mk(1, 1, 1, 1, 2, 0, 0, 0, 0, 1);
    tbl[29] = mk(1, 1, 1, 1, 2, 0, 0, 0, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i]);
      check_outs($sformatf("vec%0d", i), tbl[i].exp_stall, tbl[i].exp_bubble);
    end

    // Reset during a hold: next cycle is a fresh evaluation
    do_reset(1);
    apply(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0));
    check_outs("rst_hold.w", 2'd0, 1'b0);
    apply(mk(1, 1, 6, 0, 0, 0, 0, 0, 2, 1));
    check_outs("rst_hold.req", 2'd2, 1'b1);
    do_reset(1);
    apply(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0));
    check_outs("rst_hold.after", 2'd0, 1'b0);

    // Reset right after a writer: slots must be cleared, not shifted
    apply(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0));
    check_outs("rst_slot.w", 2'd0, 1'b0);
    do_reset(1);
    apply(mk(1, 1, 6, 1, 6, 0, 0, 0, 0, 0));
    check_outs("rst_slot.after", 2'd0, 1'b0);

    // Randomized run against the reference model
    do_reset(1);
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      v.valid = ($urandom_range(0, 7) != 0);
      v.rs_en = $urandom_range(0, 1);
      v.rs    = 3'($urandom_range(0, 7));
      v.rt_en = $urandom_range(0, 1);
      v.rt    = 3'($urandom_range(0, 7));
      v.wen   = ($urandom_range(0, 3) != 0);
      v.rd    = 3'($urandom_range(0, 7));
      v.fl    = ($urandom_range(0, 9) == 0);
      r       = ($urandom_range(0, 63) == 0);
      v.exp_stall = 2'd0; v.exp_bubble = 1'b0;
      apply(v);
      rst = r;
      if (r) begin
        model_reset();
      end else begin
        model_step(v, es, eb);
        check_outs($sformatf("rand%0d", i), es, eb);
      end
    end
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
